// File: rtl/bm_mac_pkg.sv
// ----------------------------------------------------------------------------
// bm_mac_pkg
// Shared types and constants for the block-minifloat MAC sequencer.
//   - state_e     : sequencer FSM states (IDLE, FEED, DRAIN, DONE)
//   - FRAC_W      : operand fraction (signed mantissa) width
//   - EXP_W       : operand shared-exponent width
//   - MUL_RES_W   : signed result width returned by mul_fp52
//   - DEF_MUL_LAT : default mul_fp52 latency (input, shift, output registers)
// ----------------------------------------------------------------------------
package bm_mac_pkg;

    localparam int FRAC_W      = 7;
    localparam int EXP_W       = 2;
    localparam int MUL_RES_W   = 20;
    localparam int DEF_MUL_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : bm_mac_pkg

// File: rtl/bm_mac_acc_sat.sv
// ----------------------------------------------------------------------------
// bm_mac_acc_sat
// Saturating signed accumulator. The addend is sign-extended to ACC_W, added
// to the running sum, and the result clamps to the most positive / most
// negative ACC_W-bit value on signed overflow. The overflow flag is sticky
// until the next clear.
//
// Ports:
//   clk_i       in  1       rising-edge clock
//   rst_i       in  1       synchronous active-high reset
//   clr_i       in  1       synchronous clear of sum and flag (wins over add)
//   add_en_i    in  1       add add_val_i this cycle
//   add_val_i   in  IN_W    signed addend
//   acc_o       out ACC_W   signed running sum
//   ovf_o       out 1       sticky saturation flag
//
// ACC_W must be >= IN_W.
// ----------------------------------------------------------------------------
module bm_mac_acc_sat #(
    parameter int ACC_W = 24,
    parameter int IN_W  = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             add_en_i,
    input  logic [IN_W-1:0]  add_val_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    localparam int EXT_W = ACC_W + 1 - IN_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    // One guard bit: the two top bits of the widened sum disagree exactly
    // when the ACC_W-bit signed add has overflowed.
    logic [ACC_W:0]   sum_w;

    assign sum_w = {acc_q[ACC_W-1], acc_q}
                 + {{EXT_W{add_val_i[IN_W-1]}}, add_val_i};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_en_i) begin
            case (sum_w[ACC_W:ACC_W-1])
                2'b01: begin
                    acc_d = SAT_MAX;
                    ovf_d = 1'b1;
                end
                2'b10: begin
                    acc_d = SAT_MIN;
                    ovf_d = 1'b1;
                end
                default: acc_d = sum_w[ACC_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule : bm_mac_acc_sat

// File: rtl/bm_mac_seq.sv
// ----------------------------------------------------------------------------
// bm_mac_seq
// Dot-product sequencer for one block-minifloat MAC lane. Streams up to
// 2^CNT_W-1 operand pairs per job into an external mul_fp52, injects the job
// bias on the first beat through the multiplier's c operand, tracks in-flight
// products with a valid-tag shift register, and accumulates the returned
// products into a saturating accumulator. One result per job is offered on a
// valid/ready port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and a producer holds valid and
// its payload stable until the transfer (out_* is held stable in DONE).
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i                    job request (sampled only in IDLE)
//   cfg_len_i    [CNT_W]       operand pairs in the job, captured on start
//   bias_dat_i/bias_exp_i      bias operand, captured on start
//   in_valid_i / in_ready_o    operand-pair handshake
//   in_{a,b}_{dat,exp}_i       operand pair
//   mul_{a,b,c}_{dat,exp}_o    registered multiplier operands
//   mul_res_i    [MUL_RES_W]   signed multiplier result, MUL_LAT after issue
//   busy_o                     high outside IDLE
//   out_valid_o / out_ready_i  result handshake
//   out_sum_o    [ACC_W]       signed dot product including bias
//   out_ovf_o                  sticky saturation flag for the job
//   dbg_state_o  [2]           current FSM state (state_e encoding)
// ----------------------------------------------------------------------------
module bm_mac_seq
    import bm_mac_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     cfg_len_i,
    input  logic [FRAC_W-1:0]    bias_dat_i,
    input  logic [EXP_W-1:0]     bias_exp_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [FRAC_W-1:0]    in_a_dat_i,
    input  logic [EXP_W-1:0]     in_a_exp_i,
    input  logic [FRAC_W-1:0]    in_b_dat_i,
    input  logic [EXP_W-1:0]     in_b_exp_i,
    output logic [FRAC_W-1:0]    mul_a_dat_o,
    output logic [EXP_W-1:0]     mul_a_exp_o,
    output logic [FRAC_W-1:0]    mul_b_dat_o,
    output logic [EXP_W-1:0]     mul_b_exp_o,
    output logic [FRAC_W-1:0]    mul_c_dat_o,
    output logic [EXP_W-1:0]     mul_c_exp_o,
    input  logic [MUL_RES_W-1:0] mul_res_i,
    output logic                 busy_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_W-1:0]     out_sum_o,
    output logic                 out_ovf_o,
    output logic [1:0]           dbg_state_o
);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e             state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [FRAC_W-1:0]  bias_dat_q, bias_dat_d;
    logic [EXP_W-1:0]   bias_exp_q, bias_exp_d;

    // tag_q[k] is 1 when the operands issued k+1 cycles ago were a real
    // beat; tag_q[MUL_LAT] lines up with that beat's mul_res_i.
    logic [MUL_LAT:0]   tag_q, tag_d;

    logic [FRAC_W-1:0]  mul_a_dat_q, mul_a_dat_d;
    logic [EXP_W-1:0]   mul_a_exp_q, mul_a_exp_d;
    logic [FRAC_W-1:0]  mul_b_dat_q, mul_b_dat_d;
    logic [EXP_W-1:0]   mul_b_exp_q, mul_b_exp_d;
    logic [FRAC_W-1:0]  mul_c_dat_q, mul_c_dat_d;
    logic [EXP_W-1:0]   mul_c_exp_q, mul_c_exp_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic               start_acc;
    logic               beat_acc;
    logic               last_beat;
    logic               tags_in_flight;
    logic               acc_add;
    logic [CNT_W-1:0]   cnt_inc;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign beat_acc  = in_valid_i && in_ready_o;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_beat = beat_acc && (cnt_inc == len_q);
    assign acc_add   = tag_q[MUL_LAT];

    // The tap stage is excluded: a tag sitting at the tap is accumulated on
    // the same edge that moves DRAIN to DONE, so out_sum is final in DONE.
    assign tags_in_flight = |tag_q[MUL_LAT-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // A zero-length job never touches the multiplier.
                    state_d = (cfg_len_i == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tags_in_flight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o  = 1'b0;
        busy_o      = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_FEED: begin
                busy_o     = 1'b1;
                in_ready_o = (cnt_q < len_q);
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
            end
            ST_DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state: job config, beat counter, tags, mul operands
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        bias_dat_d = bias_dat_q;
        bias_exp_d = bias_exp_q;

        if (start_acc) begin
            cnt_d      = '0;
            len_d      = cfg_len_i;
            bias_dat_d = bias_dat_i;
            bias_exp_d = bias_exp_i;
        end else if (beat_acc) begin
            cnt_d = cnt_inc;
        end

        tag_d = {tag_q[MUL_LAT-1:0], beat_acc};

        // Idle cycles issue all-zero operands so the multiplier output is
        // zero whenever no tag is present.
        mul_a_dat_d = '0;
        mul_a_exp_d = '0;
        mul_b_dat_d = '0;
        mul_b_exp_d = '0;
        mul_c_dat_d = '0;
        mul_c_exp_d = '0;
        if (beat_acc) begin
            mul_a_dat_d = in_a_dat_i;
            mul_a_exp_d = in_a_exp_i;
            mul_b_dat_d = in_b_dat_i;
            mul_b_exp_d = in_b_exp_i;
            // Bias rides on the first product only, so it is summed once.
            if (cnt_q == '0) begin
                mul_c_dat_d = bias_dat_q;
                mul_c_exp_d = bias_exp_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            len_q       <= '0;
            bias_dat_q  <= '0;
            bias_exp_q  <= '0;
            tag_q       <= '0;
            mul_a_dat_q <= '0;
            mul_a_exp_q <= '0;
            mul_b_dat_q <= '0;
            mul_b_exp_q <= '0;
            mul_c_dat_q <= '0;
            mul_c_exp_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            bias_dat_q  <= bias_dat_d;
            bias_exp_q  <= bias_exp_d;
            tag_q       <= tag_d;
            mul_a_dat_q <= mul_a_dat_d;
            mul_a_exp_q <= mul_a_exp_d;
            mul_b_dat_q <= mul_b_dat_d;
            mul_b_exp_q <= mul_b_exp_d;
            mul_c_dat_q <= mul_c_dat_d;
            mul_c_exp_q <= mul_c_exp_d;
        end
    end

    assign mul_a_dat_o = mul_a_dat_q;
    assign mul_a_exp_o = mul_a_exp_q;
    assign mul_b_dat_o = mul_b_dat_q;
    assign mul_b_exp_o = mul_b_exp_q;
    assign mul_c_dat_o = mul_c_dat_q;
    assign mul_c_exp_o = mul_c_exp_q;

    // ------------------------------------------------------------------
    // Saturating accumulator; cleared when a job is accepted
    // ------------------------------------------------------------------
    bm_mac_acc_sat #(
        .ACC_W (ACC_W),
        .IN_W  (MUL_RES_W)
    ) u_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (start_acc),
        .add_en_i  (acc_add),
        .add_val_i (mul_res_i),
        .acc_o     (out_sum_o),
        .ovf_o     (out_ovf_o)
    );

    assign dbg_state_o = state_q;

endmodule : bm_mac_seq

// File: tb/tb_bm_mac_seq.sv
// ----------------------------------------------------------------------------
// tb_bm_mac_seq
// Directed bench for bm_mac_seq. A behavioural mul_fp52 stand-in
// ((a*b) << (ea+eb) + c << ec, three register stages) feeds mul_res. Each
// job's expected {ovf, sum} comes from a plain saturating-sum model and is
// queued; a per-cycle compare process checks results, issued operands and
// completion latency, and the driver tasks check hand-computed literals.
// ----------------------------------------------------------------------------
module tb_bm_mac_seq;

  localparam int MUL_LAT = 3;
  localparam int ACC_W   = 24;
  localparam int CNT_W   = 8;
  localparam longint SMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (ACC_W - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic             start_i;
  logic [CNT_W-1:0] cfg_len_i;
  logic [6:0]       bias_dat_i;
  logic [1:0]       bias_exp_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [6:0]       in_a_dat_i, in_b_dat_i;
  logic [1:0]       in_a_exp_i, in_b_exp_i;
  logic [6:0]       mul_a_dat_o, mul_b_dat_o, mul_c_dat_o;
  logic [1:0]       mul_a_exp_o, mul_b_exp_o, mul_c_exp_o;
  logic [19:0]      mul_res_i;
  logic             busy_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ACC_W-1:0] out_sum_o;
  logic             out_ovf_o;
  logic [1:0]       dbg_state_o;

  bm_mac_seq #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cfg_len_i   (cfg_len_i),
    .bias_dat_i  (bias_dat_i),
    .bias_exp_i  (bias_exp_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_dat_i  (in_a_dat_i),
    .in_a_exp_i  (in_a_exp_i),
    .in_b_dat_i  (in_b_dat_i),
    .in_b_exp_i  (in_b_exp_i),
    .mul_a_dat_o (mul_a_dat_o),
    .mul_a_exp_o (mul_a_exp_o),
    .mul_b_dat_o (mul_b_dat_o),
    .mul_b_exp_o (mul_b_exp_o),
    .mul_c_dat_o (mul_c_dat_o),
    .mul_c_exp_o (mul_c_exp_o),
    .mul_res_i   (mul_res_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sum_o   (out_sum_o),
    .out_ovf_o   (out_ovf_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- multiplier stand-in ----------------
  function automatic logic [19:0] mul_model(input logic [6:0] a, input logic [1:0] ea,
                                            input logic [6:0] b, input logic [1:0] eb,
                                            input logic [6:0] c, input logic [1:0] ec);
    int r;
    r = (int'($signed(a)) * int'($signed(b))) * (1 << (int'(ea) + int'(eb)))
      + int'($signed(c)) * (1 << int'(ec));
    return r[19:0];
  endfunction

  logic [19:0] mp0 = '0, mp1 = '0, mp2 = '0;
  always @(posedge clk) begin
    mp0 <= mul_model(mul_a_dat_o, mul_a_exp_o, mul_b_dat_o, mul_b_exp_o, mul_c_dat_o, mul_c_exp_o);
    mp1 <= mp0;
    mp2 <= mp1;
  end
  assign mul_res_i = mp2;

  // ---------------- beat tables and job model ----------------
  logic [6:0] t_adat[256];
  logic [1:0] t_aexp[256];
  logic [6:0] t_bdat[256];
  logic [1:0] t_bexp[256];

  task automatic fill(input int n, input logic [6:0] a, input logic [1:0] ea,
                      input logic [6:0] b, input logic [1:0] eb);
    for (int i = 0; i < n; i++) begin
      t_adat[i] = a; t_aexp[i] = ea; t_bdat[i] = b; t_bexp[i] = eb;
    end
  endtask

  // Dot product with the bias added once, clamped after every step.
  function automatic logic [ACC_W:0] model_job(input int len, input logic [6:0] bd,
                                               input logic [1:0] be);
    longint acc;
    longint p;
    logic   ovf;
    logic [ACC_W-1:0] s;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < len; i++) begin
      p = longint'(int'($signed(t_adat[i])) * int'($signed(t_bdat[i])))
        * (longint'(1) << (int'(t_aexp[i]) + int'(t_bexp[i])));
      if (i == 0) p = p + longint'(int'($signed(bd))) * (longint'(1) << int'(be));
      acc = acc + p;
      if (acc > SMAX) begin acc = SMAX; ovf = 1'b1; end
      if (acc < SMIN) begin acc = SMIN; ovf = 1'b1; end
    end
    s = acc[ACC_W-1:0];
    return {ovf, s};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_W:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_beat_cyc = 0;
  int          job_len = 0;
  int          beat_idx = 0;
  logic [6:0]  job_bd = '0;
  logic [1:0]  job_be = '0;
  logic        pend_hs = 1'b0;
  logic [26:0] pend_mul = '0;
  logic        prev_ov = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      pend_hs = 1'b0;
      prev_ov = 1'b0;
    end else begin
      // Operands issued for the beat accepted last cycle, zero otherwise.
      chk("mul_ops", {mul_a_dat_o, mul_a_exp_o, mul_b_dat_o, mul_b_exp_o, mul_c_dat_o, mul_c_exp_o},
          pend_hs ? pend_mul : 27'd0);
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid_o, 1'b0);
        end else begin
          chk("out_sum", out_sum_o, exp_q[0][ACC_W-1:0]);
          chk("out_ovf", out_ovf_o, exp_q[0][ACC_W]);
        end
        if (!prev_ov) begin
          if (job_len == 0) chk("lat_zero_len", cyc - start_cyc, 1);
          else              chk("lat_last_beat", cyc - last_beat_cyc, MUL_LAT + 2);
        end
        if (out_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_ov = out_valid_o;

      pend_hs = in_valid_i && in_ready_o;
      if (pend_hs) begin
        pend_mul = {in_a_dat_i, in_a_exp_i, in_b_dat_i, in_b_exp_i,
                    (beat_idx == 0) ? job_bd : 7'd0, (beat_idx == 0) ? job_be : 2'd0};
        beat_idx++;
        last_beat_cyc = cyc;
      end
      if (start_i && !busy_o) begin
        start_cyc = cyc;
        job_len   = int'(cfg_len_i);
        job_bd    = bias_dat_i;
        job_be    = bias_exp_i;
        beat_idx  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int len, input logic [6:0] bd, input logic [1:0] be);
    @(posedge clk); #1;
    start_i    = 1'b1;
    cfg_len_i  = CNT_W'(len);
    bias_dat_i = bd;
    bias_exp_i = be;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("in_ready_after_start", in_ready_o, (len != 0));
  endtask

  task automatic feed(input int len, input int gap_max);
    int w;
    for (int i = 0; i < len; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
      in_valid_i = 1'b1;
      in_a_dat_i = t_adat[i]; in_a_exp_i = t_aexp[i];
      in_b_dat_i = t_bdat[i]; in_b_exp_i = t_bexp[i];
      w = 0;
      while (!in_ready_o && w < 50) begin @(posedge clk); #1; w++; end
      if (w == 50) chk("in_ready_timeout", in_ready_o, 1'b1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
    end
  endtask

  task automatic run_job(input string tag, input int len, input logic [6:0] bd,
                         input logic [1:0] be, input int gap_max, input int hold,
                         input logic [ACC_W-1:0] lit_sum, input logic lit_ovf);
    logic [ACC_W:0] e;
    int w;
    e = model_job(len, bd, be);
    chk({tag, "_model"}, e, {lit_ovf, lit_sum});
    exp_q.push_back(e);
    do_start(len, bd, be);
    feed(len, gap_max);
    out_ready_i = (hold == 0);
    w = 0;
    while (!out_valid_o && w < 300) begin @(posedge clk); #1; w++; end
    if (w == 300) chk({tag, "_valid_timeout"}, out_valid_o, 1'b1);
    if (hold > 0) begin
      start_i   = 1'b1;           // must be ignored in DONE
      cfg_len_i = 8'd5;
      repeat (hold) begin
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({tag, "_hold_valid"}, out_valid_o, 1'b1);
        chk({tag, "_hold_sum"}, out_sum_o, lit_sum);
      end
    end
    chk({tag, "_sum"}, out_sum_o, lit_sum);
    chk({tag, "_ovf"}, out_ovf_o, lit_ovf);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, out_valid_o, 1'b0);
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic run_reset_job();
    fill(4, 7'h40, 2'd3, 7'h40, 2'd3);
    do_start(4, 7'd0, 2'd0);
    feed(2, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_state", dbg_state_o, 2'd0);
    chk("rst_mid_in_ready", in_ready_o, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_mid_no_valid", out_valid_o, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1; start_i = 1'b0; cfg_len_i = '0; bias_dat_i = '0; bias_exp_i = '0;
    in_valid_i = 1'b0; in_a_dat_i = '0; in_a_exp_i = '0; in_b_dat_i = '0; in_b_exp_i = '0;
    out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_ovf", out_ovf_o, 1'b0);
    chk("rst_out_sum", out_sum_o, 24'd0);
    chk("rst_mul", {mul_a_dat_o, mul_a_exp_o, mul_b_dat_o, mul_b_exp_o, mul_c_dat_o, mul_c_exp_o}, 27'd0);
    chk("rst_state", dbg_state_o, 2'd0);

    fill(1, 7'd16, 2'd0, 7'd16, 2'd0);
    run_job("basic", 1, 7'd4, 2'd0, 0, 0, 24'd260, 1'b0);

    fill(4, 7'd16, 2'd1, 7'd16, 2'd1);
    run_job("exp_nobias", 4, 7'd0, 2'd0, 0, 0, 24'd4096, 1'b0);
    run_job("exp_bias1", 4, 7'd1, 2'd0, 0, 0, 24'd4097, 1'b0);

    fill(1, 7'h7F, 2'd0, 7'd5, 2'd0);
    run_job("neg", 1, 7'd0, 2'd0, 0, 0, 24'hFFFFFB, 1'b0);

    run_job("zero_len", 0, 7'd9, 2'd0, 0, 0, 24'd0, 1'b0);

    fill(32, 7'h40, 2'd3, 7'h40, 2'd3);
    run_job("sat_pos", 32, 7'd0, 2'd0, 0, 0, 24'h7FFFFF, 1'b1);

    fill(33, 7'h40, 2'd3, 7'h3F, 2'd3);
    run_job("sat_neg", 33, 7'd0, 2'd0, 1, 0, 24'h800000, 1'b1);

    t_adat[0] = 7'd10; t_aexp[0] = 2'd0; t_bdat[0] = 7'h7D; t_bexp[0] = 2'd1;
    t_adat[1] = 7'd7;  t_aexp[1] = 2'd2; t_bdat[1] = 7'd9;  t_bexp[1] = 2'd0;
    t_adat[2] = 7'h7F; t_aexp[2] = 2'd3; t_bdat[2] = 7'h7F; t_bexp[2] = 2'd3;
    run_job("mixed", 3, 7'd2, 2'd0, 0, 0, 24'd258, 1'b0);

    fill(8, 7'd3, 2'd0, 7'd2, 2'd0);
    run_job("backpressure", 8, 7'd0, 2'd0, 3, 10, 24'd48, 1'b0);

    run_reset_job();
    fill(2, 7'd1, 2'd0, 7'd1, 2'd0);
    run_job("after_reset", 2, 7'd0, 2'd0, 0, 0, 24'd2, 1'b0);

    repeat (5) @(posedge clk);
    #1 chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_bm_mac_seq
